// File: rtl/cv_text_loader.sv
// Character text loader: bytes fill a shadow buffer; a commit copies it atomically to text_out.
// Optional macro CV_TEXT_SYNC_COMMIT_EN defers each commit to the next frame_start pulse.
module cv_text_loader #(
    parameter int unsigned NOF_CHARS = 12,
    parameter logic [7:0]  PAD_CHAR  = 8'h20
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_valid,
    input  logic [7:0]                         wr_data,
    output logic                               wr_ready,
    input  logic                               frame_start,
    output logic [8*NOF_CHARS-1:0]             text_out,
    output logic [$clog2(NOF_CHARS+1)-1:0]     cursor,
    output logic                               overflow,
    output logic                               commit_done
);

    localparam int unsigned CW = $clog2(NOF_CHARS + 1);
    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] shadow [NOF_CHARS];
    logic       accept_c;
    logic       commit_c;

    assign wr_ready = (state == FILL);
    assign accept_c = wr_valid && wr_ready;

`ifdef CV_TEXT_SYNC_COMMIT_EN
    // Commit only on a frame boundary so the display never changes mid-frame.
    assign commit_c = (state == PENDING) && frame_start;
`else
    assign commit_c = (state == PENDING);
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            text_out    <= {NOF_CHARS{PAD_CHAR}};
            cursor      <= '0;
            overflow    <= 1'b0;
            commit_done <= 1'b0;
            for (int unsigned i = 0; i < NOF_CHARS; i++) begin
                shadow[i] <= PAD_CHAR;
            end
        end else begin
            commit_done <= 1'b0;
            if (commit_c) begin
                // Whole string moves in one edge; shadow restarts empty.
                for (int unsigned i = 0; i < NOF_CHARS; i++) begin
                    text_out[8*(NOF_CHARS-i)-1 -: 8] <= shadow[i];
                    shadow[i] <= PAD_CHAR;
                end
                cursor      <= '0;
                overflow    <= 1'b0;
                commit_done <= 1'b1;
                state       <= FILL;
            end else if (accept_c) begin
                case (wr_data)
                    CODE_FF: begin
                        for (int unsigned i = 0; i < NOF_CHARS; i++) begin
                            shadow[i] <= PAD_CHAR;
                        end
                        cursor   <= '0;
                        overflow <= 1'b0;
                    end
                    CODE_LF: begin
                        state <= PENDING;
                    end
                    CODE_BS: begin
                        if (cursor != '0) begin
                            cursor <= cursor - CW'(1);
                            for (int unsigned i = 0; i < NOF_CHARS; i++) begin
                                if (CW'(i) == cursor - CW'(1)) begin
                                    shadow[i] <= PAD_CHAR;
                                end
                            end
                        end
                    end
                    default: begin
                        if (cursor < CW'(NOF_CHARS)) begin
                            for (int unsigned i = 0; i < NOF_CHARS; i++) begin
                                if (CW'(i) == cursor) begin
                                    shadow[i] <= wr_data;
                                end
                            end
                            cursor <= cursor + CW'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cv_text_loader.sv
// Directed bench for cv_text_loader: fill, overflow, backspace, clear, commit timing, reset abort.
// Covers both builds; sync-commit steps are selected with CV_TEXT_SYNC_COMMIT_EN.
module tb_cv_text_loader;

    localparam int unsigned N  = 12;
    localparam int unsigned CW = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_valid = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              wr_ready;
    logic              frame_start = 1'b0;
    logic [8*N-1:0]    text_out;
    logic [CW-1:0]     cursor;
    logic              overflow;
    logic              commit_done;

    int n_cmp  = 0;
    int n_fail = 0;

    cv_text_loader #(.NOF_CHARS(N), .PAD_CHAR(8'h20)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .frame_start (frame_start),
        .text_out    (text_out),
        .cursor      (cursor),
        .overflow    (overflow),
        .commit_done (commit_done)
    );

    always #5 clk = ~clk;

    function automatic logic [8*N-1:0] make_text(input string s);
        logic [8*N-1:0] r;
        logic [7:0]     c;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            c = (i < s.len()) ? 8'(s[i]) : 8'h20;
            r[8*(int'(N)-i)-1 -: 8] = c;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [8*N-1:0] obs, input logic [8*N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = b;
        while (!wr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!wr_ready) begin
            check("ready_timeout", 96'(wr_ready), 96'(1));
            wr_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(8'(s[i]));
        end
    endtask

    // Accept a commit code, then pulse frame_start on the following edge.
    task automatic do_commit(input string tag);
        send_byte(8'h0A);
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        check({tag, "_commit_done"}, 96'(commit_done), 96'(1));
    endtask

    initial begin
        logic [8*N-1:0] prev;

        // Reset state
        #2 reset = 1'b1;
        #2;
        check("rst_text", text_out, make_text(""));
        check("rst_cursor", 96'(cursor), 96'(0));
        check("rst_overflow", 96'(overflow), 96'(0));
        check("rst_commit_done", 96'(commit_done), 96'(0));
        check("rst_wr_ready", 96'(wr_ready), 96'(1));
        @(negedge clk);
        reset = 1'b0;

        // "HI" then commit on frame_start
        send_str("HI");
        check("hi_cursor", 96'(cursor), 96'(2));
        send_byte(8'h0A);
        check("hi_pending_ready", 96'(wr_ready), 96'(0));
        check("hi_pending_text", text_out, make_text(""));
        check("hi_pending_cd", 96'(commit_done), 96'(0));
        check("hi_pending_cursor", 96'(cursor), 96'(2));
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        check("hi_text", text_out, make_text("HI"));
        check("hi_commit_done", 96'(commit_done), 96'(1));
        check("hi_cursor0", 96'(cursor), 96'(0));
        check("hi_ready", 96'(wr_ready), 96'(1));
        @(posedge clk);
        #1;
        check("hi_cd_pulse_end", 96'(commit_done), 96'(0));
        check("hi_text_hold", text_out, make_text("HI"));

        // Overflow: 14 bytes into 12 slots
        send_str("ABCDEFGHIJKL");
        check("ovf_cursor_full", 96'(cursor), 96'(12));
        check("ovf_not_yet", 96'(overflow), 96'(0));
        send_byte("M");
        check("ovf_set", 96'(overflow), 96'(1));
        send_byte("N");
        check("ovf_cursor_hold", 96'(cursor), 96'(12));
        check("ovf_sticky", 96'(overflow), 96'(1));
        do_commit("ovf");
        check("ovf_text", text_out, make_text("ABCDEFGHIJKL"));
        check("ovf_cleared", 96'(overflow), 96'(0));
        check("ovf_cursor0", 96'(cursor), 96'(0));

        // Backspace
        send_str("AB");
        send_byte(8'h08);
        check("bs1_cursor", 96'(cursor), 96'(1));
        do_commit("bs1");
        check("bs1_text", text_out, make_text("A"));
        send_str("AB");
        send_byte(8'h08);
        send_byte(8'h08);
        send_byte(8'h08);
        check("bs3_cursor", 96'(cursor), 96'(0));
        do_commit("bs3");
        check("bs3_text", text_out, make_text(""));

        // Clear on a full, overflowed buffer
        send_str("abcdefghijklm");
        check("clr_pre_ovf", 96'(overflow), 96'(1));
        send_byte(8'h0C);
        check("clr_cursor", 96'(cursor), 96'(0));
        check("clr_overflow", 96'(overflow), 96'(0));
        check("clr_text_hold", text_out, make_text(""));
        send_byte("Q");
        do_commit("clr");
        check("clr_text", text_out, make_text("Q"));

        // Commit code coincident with frame_start; "Z" held during PENDING
        send_str("XY");
        prev = text_out;
        @(negedge clk);
        wr_valid    = 1'b1;
        wr_data     = 8'h0A;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        wr_data     = "Z";
        check("co_cd", 96'(commit_done), 96'(0));
        check("co_ready", 96'(wr_ready), 96'(0));
        check("co_text", text_out, prev);
        check("co_cursor", 96'(cursor), 96'(2));
`ifdef CV_TEXT_SYNC_COMMIT_EN
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("sync_wait_cd", 96'(commit_done), 96'(0));
            check("sync_wait_cursor", 96'(cursor), 96'(2));
            check("sync_wait_text", text_out, prev);
        end
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
`else
        @(posedge clk);
        #1;
`endif
        check("co_commit_cd", 96'(commit_done), 96'(1));
        check("co_commit_text", text_out, make_text("XY"));
        check("co_commit_cursor", 96'(cursor), 96'(0));
        check("co_commit_ready", 96'(wr_ready), 96'(1));
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check("z_cursor", 96'(cursor), 96'(1));
        check("z_cd_low", 96'(commit_done), 96'(0));
        do_commit("z");
        check("z_text", text_out, make_text("Z"));

        // Reset in PENDING discards the commit
        send_str("RS");
        send_byte(8'h0A);
        check("rp_pending", 96'(wr_ready), 96'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rp_text", text_out, make_text(""));
        check("rp_ready", 96'(wr_ready), 96'(1));
        check("rp_cursor", 96'(cursor), 96'(0));
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rp_text_after", text_out, make_text(""));
        check("rp_cd_after", 96'(commit_done), 96'(0));
        check("rp_ready_after", 96'(wr_ready), 96'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
